// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO page (LED, cycle counter, serial TX).
// Latency: reads are combinational from dmem_addr; writes take effect at the next rising clk.
// Backpressure: none; a TX byte written while a frame is in flight is dropped and flagged as overrun.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          CLK_DIV     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        tx_out,
    output logic [7:0]  leds
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_CYCLE  = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_TXSTAT = 8'h0C;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [7:0]    r_led;
    logic [31:0]   r_cycle;
    logic          r_ovr;
    logic [7:0]    r_data;
    logic          r_tx;
    tx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;

    tx_state_t     w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_tx_nxt;
    logic          w_accept;

    logic          w_mmio;
    logic [7:0]    w_off;
    logic [AW-1:0] w_ram_idx;
    logic          w_ram_we;
    logic          w_led_we;
    logic          w_txd_we;
    logic          w_txs_we;
    logic          w_busy;
    logic          w_unused_bits;

    // Address decode; bits [15:8] of an MMIO address and the RAM alias bits are don't-care.
    assign w_mmio    = (dmem_addr[31:16] == MMIO_BASE[31:16]);
    assign w_off     = dmem_addr[7:0];
    assign w_ram_idx = dmem_addr[AW+1:2];
    assign w_ram_we  = dmem_we && !w_mmio;
    assign w_led_we  = dmem_we && w_mmio && (w_off == OFF_LED);
    assign w_txd_we  = dmem_we && w_mmio && (w_off == OFF_TXDATA);
    assign w_txs_we  = dmem_we && w_mmio && (w_off == OFF_TXSTAT);
    assign w_busy    = (r_state != S_IDLE);
    assign w_unused_bits = ^{dmem_addr[15:0], dmem_wdata, MMIO_BASE[15:0]};

    assign tx_out = r_tx;
    assign leds   = r_led;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_idx] <= dmem_wdata;
        end
    end

    // Combinational load path: RAM word or MMIO register view.
    always_comb begin
        dmem_rdata = 32'd0;
        if (w_mmio) begin
            case (w_off)
                OFF_LED:    dmem_rdata = {24'd0, r_led};
                OFF_CYCLE:  dmem_rdata = r_cycle;
                OFF_TXSTAT: dmem_rdata = {30'd0, r_ovr, w_busy};
                default:    dmem_rdata = 32'd0;
            endcase
        end else begin
            dmem_rdata = r_mem[w_ram_idx];
        end
    end

    // LED register, free-running cycle counter and sticky overrun flag (set beats clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led   <= 8'd0;
            r_cycle <= 32'd0;
            r_ovr   <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_led_we) begin
                r_led <= dmem_wdata[7:0];
            end
            if (w_txd_we && w_busy) begin
                r_ovr <= 1'b1;
            end else if (w_txs_we && dmem_wdata[1]) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // TX state register, bit timer, bit index, byte latch and registered serial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_data  <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // TX next-state logic; the line level is derived from the next state so tx_out is a clean flop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_txd_we) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_data_nxt = w_accept ? dmem_wdata[7:0] : r_data;

        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_data_nxt[w_idx_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a behavioural model.
// Latency: outputs sampled 1ns after the falling edge, model advanced at each rising edge.
// Backpressure: not applicable; TX overrun behaviour is modelled explicitly.
module tb_dmem_responder;

    localparam int CD = 4;
    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0004;
    localparam logic [31:0] A_TXD  = 32'hFFFF_0008;
    localparam logic [31:0] A_TXS  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        tx_out;
    logic [7:0]  leds;

    dmem_responder #(
        .DEPTH_WORDS(256),
        .MMIO_BASE  (32'hFFFF_0000),
        .CLK_DIV    (CD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .tx_out    (tx_out),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    logic [31:0] m_mem [256];
    bit          m_vld [256];
    logic [7:0]  m_led;
    logic [31:0] m_cyc;
    bit          m_ovr;
    int          m_pos;      // 0 = idle, else 1..10*CD cycles into the frame
    logic [7:0]  m_byte;

    logic [31:0] rd;
    logic        last_tx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic exp_tx();
        int b;
        if (m_pos == 0) return 1'b1;
        b = (m_pos - 1) / CD;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    task automatic model_reset();
        m_led = 8'd0;
        m_cyc = 32'd0;
        m_ovr = 1'b0;
        m_pos = 0;
    endtask

    // One bus cycle: drive at the falling edge, check, then advance the model across the rising edge.
    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e;
        bit known, mm;
        int idx;
        logic [7:0] off;
        dmem_we = we; dmem_addr = a; dmem_wdata = d;
        #1;
        rd = dmem_rdata;
        last_tx = tx_out;
        mm = (a[31:16] == 16'hFFFF);
        off = a[7:0];
        idx = int'(a[9:2]);
        known = 1'b1;
        e = 32'd0;
        if (mm) begin
            case (off)
                8'h00: e = {24'd0, m_led};
                8'h04: e = m_cyc;
                8'h0C: e = {30'd0, m_ovr, (m_pos != 0)};
                default: e = 32'd0;
            endcase
        end else begin
            known = m_vld[idx];
            e = m_mem[idx];
        end
        if (known) chk("rdata", rd, e);
        chk("tx_out", {31'd0, tx_out}, {31'd0, exp_tx()});
        chk("leds", {24'd0, leds}, {24'd0, m_led});
        @(posedge clk);
        if (we && !mm) begin m_mem[idx] = d; m_vld[idx] = 1'b1; end
        if (we && mm && off == 8'h00) m_led = d[7:0];
        m_cyc = m_cyc + 32'd1;
        if (we && mm && off == 8'h08 && m_pos != 0) m_ovr = 1'b1;
        else if (we && mm && off == 8'h0C && d[1]) m_ovr = 1'b0;
        if (m_pos != 0) m_pos = (m_pos == 10*CD) ? 0 : m_pos + 1;
        else if (we && mm && off == 8'h08) begin m_pos = 1; m_byte = d[7:0]; end
        @(negedge clk);
    endtask

    // Asynchronous reset at a falling edge; outputs must react without waiting for a clock.
    task automatic do_reset();
        dmem_we = 1'b0;
        dmem_addr = A_TXS;
        rst = 1'b0;
        #1;
        chk("rst_tx", {31'd0, tx_out}, 32'd1);
        chk("rst_leds", {24'd0, leds}, 32'd0);
        chk("rst_txstat", dmem_rdata, 32'd0);
        dmem_addr = A_CYC;
        #1;
        chk("rst_cycle", dmem_rdata, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int pat [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int nb, guard, r;
        logic [31:0] a;
        logic [7:0]  offs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h00};

        for (int i = 0; i < 256; i++) begin m_vld[i] = 1'b0; m_mem[i] = 32'd0; end
        m_byte = 8'd0;
        rst = 1'b1; dmem_we = 1'b0; dmem_addr = 32'd0; dmem_wdata = 32'd0;
        #2 rst = 1'b0;
        @(negedge clk);
        do_reset();

        // Cycle counter: 100 edges after release, writes ignored.
        repeat (100) cyc(1'b0, A_LED, 32'd0);
        cyc(1'b0, A_CYC, 32'd0);
        chk("cycle_100", rd, 32'd100);
        cyc(1'b1, A_CYC, 32'd0);
        cyc(1'b0, A_CYC, 32'd0);
        chk("cycle_wr_ignored", rd, 32'd102);

        // RAM write, byte-offset and aliased reads, old value on same-cycle read.
        cyc(1'b1, 32'h0000_0010, 32'hDEADBEEF);
        cyc(1'b0, 32'h0000_0010, 32'd0);
        chk("ram_10", rd, 32'hDEADBEEF);
        cyc(1'b0, 32'h0000_0013, 32'd0);
        chk("ram_13", rd, 32'hDEADBEEF);
        cyc(1'b0, 32'h0000_0410, 32'd0);
        chk("ram_alias", rd, 32'hDEADBEEF);
        cyc(1'b1, 32'h0000_0010, 32'h1234_5678);
        chk("ram_old_val", rd, 32'hDEADBEEF);

        // TX frame for 0xA5: fixed waveform and exactly 40 busy cycles.
        cyc(1'b1, A_TXD, 32'h0000_00A5);
        nb = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, A_TXS, 32'd0);
            if (rd[0]) nb++;
            if (i < 10*CD) chk("a5_wave", {31'd0, last_tx}, pat[i/CD]);
        end
        chk("busy_len", nb, 40);

        // Overrun: drop during frame, W1C, drop in last STOP cycle, accept in first IDLE cycle.
        cyc(1'b1, A_TXD, 32'h0000_00A5);
        repeat (10) cyc(1'b0, A_LED, 32'd0);
        cyc(1'b1, A_TXD, 32'h0000_003C);
        cyc(1'b0, A_TXS, 32'd0);
        chk("ovr_set", rd, 32'd3);
        cyc(1'b1, A_TXS, 32'd2);
        cyc(1'b0, A_TXS, 32'd0);
        chk("ovr_clr", rd, 32'd1);
        guard = 0;
        while (m_pos != 10*CD && guard < 60) begin cyc(1'b0, A_TXS, 32'd0); guard++; end
        chk("stop_wait", m_pos, 10*CD);
        cyc(1'b1, A_TXD, 32'h0000_0055);
        cyc(1'b1, A_TXD, 32'h0000_0066);
        cyc(1'b0, A_TXS, 32'd0);
        chk("idle_accept", rd, 32'd3);

        // Reset mid-DATA, then a fresh frame.
        repeat (15) cyc(1'b0, A_TXS, 32'd0);
        do_reset();
        cyc(1'b1, A_TXD, 32'h0000_0081);
        repeat (45) cyc(1'b0, A_TXS, 32'd0);

        // LED register and unmapped offset.
        cyc(1'b1, A_LED, 32'h0000_01FF);
        cyc(1'b0, A_LED, 32'd0);
        chk("led_rd", rd, 32'h0000_00FF);
        chk("led_pin", {24'd0, leds}, 32'h0000_00FF);
        cyc(1'b0, 32'hFFFF_0010, 32'd0);
        chk("unmapped", rd, 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            r = $urandom_range(0, 9);
            if (r < 4) begin
                a = $urandom;
                if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
                a[9:2] = 8'($urandom_range(0, 15));
                cyc($urandom_range(0, 2) == 0, a, $urandom);
            end else begin
                a = {16'hFFFF, 8'($urandom), offs[$urandom_range(0, 5)]};
                if ($urandom_range(0, 7) == 0) a[7:0] = 8'($urandom);
                cyc($urandom_range(0, 3) == 0, a, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
